// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

   typedef enum logic [1:0] {IDLE, ITER, FIX} state_e;

   localparam int DEF_WIDTH = 8;
   localparam int CNT_W     = $clog2(DEF_WIDTH);

   // Sign bit of a w-bit value carried in a 32-bit container.
   function automatic logic sign_of(input logic [31:0] x, input int w);
      return x[w-1];
   endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle for seq_divider; the divider sits on the slave side.
interface seq_divider_if #(parameter int WIDTH = 8);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             dbz;
   logic             ovf;

   modport master (output start, dividend, divisor,
                   input  ready, busy, done, quotient, remainder, dbz, ovf);
   modport slave  (input  start, dividend, divisor,
                   output ready, busy, done, quotient, remainder, dbz, ovf);
endinterface

// File: rtl/div_cond_neg.sv
// Conditional two's-complement negate: y = neg ? -x : x.
module div_cond_neg #(parameter int WIDTH = 8) (
   input  logic             neg,
   input  logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y
);
   assign y = neg ? ('0 - x) : x;
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, signed or unsigned.
// Optional SEQ_DIVIDER_FLAGS_EN adds divide-by-zero and MIN/-1 overflow flags.
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter bit SIGNED = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   seq_divider_if.slave  bus
);
   localparam int CNTW = $clog2(WIDTH);

   state_e           state_q, state_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, q_q, q_d, d_q, d_d;
   logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
   logic             qneg_q, qneg_d, rneg_q, rneg_d, done_q, done_d;
   logic [WIDTH-1:0] dvd_mag, dvs_mag, quo_fix, rem_fix;
   logic [WIDTH+1:0] trial;
   logic             dvd_s, dvs_s;

   assign dvd_s = SIGNED & bus.dividend[WIDTH-1];
   assign dvs_s = SIGNED & bus.divisor[WIDTH-1];

   div_cond_neg #(.WIDTH(WIDTH)) u_neg_dvd (.neg(dvd_s),  .x(bus.dividend), .y(dvd_mag));
   div_cond_neg #(.WIDTH(WIDTH)) u_neg_dvs (.neg(dvs_s),  .x(bus.divisor),  .y(dvs_mag));
   div_cond_neg #(.WIDTH(WIDTH)) u_neg_quo (.neg(qneg_q), .x(q_q),          .y(quo_fix));
   div_cond_neg #(.WIDTH(WIDTH)) u_neg_rem (.neg(rneg_q), .x(a_q),          .y(rem_fix));

   // Trial subtract on the shifted partial remainder {A,Q[msb]}; keeping the
   // shifted-out bit lets unsigned divisors above 2^(WIDTH-1) work.
   assign trial = {1'b0, a_q, q_q[WIDTH-1]} - {2'b00, d_q};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      q_d     = q_q;
      d_d     = d_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (bus.start) begin
            state_d = ITER;
            a_d     = '0;
            q_d     = dvd_mag;
            d_d     = dvs_mag;
            cnt_d   = '0;
            qneg_d  = dvd_s ^ dvs_s;
            rneg_d  = dvd_s;
         end
         ITER: begin
            if (!trial[WIDTH+1]) begin
               a_d = trial[WIDTH-1:0];
               q_d = {q_q[WIDTH-2:0], 1'b1};
            end else begin
               a_d = {a_q[WIDTH-2:0], q_q[WIDTH-1]};
               q_d = {q_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNTW'(WIDTH-1)) state_d = FIX;
         end
         FIX: begin
            quo_d   = quo_fix;
            rem_d   = rem_fix;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         q_q     <= q_d;
         d_q     <= d_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         done_q  <= done_d;
      end
   end

`ifdef SEQ_DIVIDER_FLAGS_EN
   // Flags captured at accept, published together with the results.
   logic dbzp_q, dbzp_d, ovfp_q, ovfp_d, dbz_q, dbz_d, ovf_q, ovf_d;

   always_comb begin
      dbzp_d = dbzp_q;
      ovfp_d = ovfp_q;
      dbz_d  = dbz_q;
      ovf_d  = ovf_q;
      if (state_q == IDLE && bus.start) begin
         dbzp_d = (bus.divisor == '0);
         ovfp_d = SIGNED && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.divisor == '1);
      end
      if (state_q == FIX) begin
         dbz_d = dbzp_q;
         ovf_d = ovfp_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dbzp_q <= 1'b0;
         ovfp_q <= 1'b0;
         dbz_q  <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         dbzp_q <= dbzp_d;
         ovfp_q <= ovfp_d;
         dbz_q  <= dbz_d;
         ovf_q  <= ovf_d;
      end
   end

   assign bus.dbz = dbz_q;
   assign bus.ovf = ovf_q;
`else
   assign bus.dbz = 1'b0;
   assign bus.ovf = 1'b0;
`endif

   assign bus.ready     = (state_q == IDLE);
   assign bus.busy      = (state_q == ITER) || (state_q == FIX);
   assign bus.done      = done_q;
   assign bus.quotient  = quo_q;
   assign bus.remainder = rem_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed + random bench for seq_divider (8-bit signed and 16-bit unsigned instances).
module tb_seq_divider;
   import div_pkg::*;

`ifdef SEQ_DIVIDER_FLAGS_EN
   localparam bit FL = 1'b1;
`else
   localparam bit FL = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seq_divider_if #(.WIDTH(8))  b8();
   seq_divider_if #(.WIDTH(16)) b16();

   seq_divider #(.WIDTH(8),  .SIGNED(1'b1)) dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
   seq_divider #(.WIDTH(16), .SIGNED(1'b0)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

   typedef struct {
      logic [15:0] q;
      logic [15:0] r;
      logic        dbz;
      logic        ovf;
   } exp_t;

   exp_t sb8[$];
   exp_t sb16[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      int sa, sbv, qi, ri;
      sa  = int'($signed(a));
      sbv = int'($signed(b));
      if (b == 8'h00) begin
         qi = sign_of({24'h0, a}, 8) ? 1 : 255;
         ri = sa;
      end else begin
         qi = sa / sbv;
         ri = sa % sbv;
      end
      e.q   = {8'h00, 8'(qi)};
      e.r   = {8'h00, 8'(ri)};
      e.dbz = FL && (b == 8'h00);
      e.ovf = FL && (a == 8'h80) && (b == 8'hFF);
      return e;
   endfunction

   function automatic exp_t model16(input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      e.q   = (b == 16'h0) ? 16'hFFFF : a / b;
      e.r   = (b == 16'h0) ? a : a % b;
      e.dbz = FL && (b == 16'h0);
      e.ovf = 1'b0;
      return e;
   endfunction

   // Issue one 8-bit operation and check its result at done.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit hold);
      int lat;
      bit busy_ok;
      exp_t e;
      sb8.push_back(model8(a, b));
      b8.dividend = a;
      b8.divisor  = b;
      b8.start    = 1'b1;
      @(posedge clk); #1;
      if (!hold) b8.start = 1'b0;
      lat = 0;
      busy_ok = 1'b1;
      while (!b8.done && lat < 40) begin
         if (!b8.busy) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      b8.start = 1'b0;
      e = sb8.pop_front();
      chk("lat8", lat, 9);
      chk("busy8", busy_ok, 1);
      chk("ready_done8", {b8.ready, b8.busy}, 2'b10);
      chk("quo8", b8.quotient, e.q);
      chk("rem8", b8.remainder, e.r);
      chk("flags8", {b8.dbz, b8.ovf}, {e.dbz, e.ovf});
   endtask

   task automatic op16(input logic [15:0] a, input logic [15:0] b);
      int lat;
      bit busy_ok;
      exp_t e;
      sb16.push_back(model16(a, b));
      b16.dividend = a;
      b16.divisor  = b;
      b16.start    = 1'b1;
      @(posedge clk); #1;
      b16.start = 1'b0;
      lat = 0;
      busy_ok = 1'b1;
      while (!b16.done && lat < 60) begin
         if (!b16.busy) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      e = sb16.pop_front();
      chk("lat16", lat, 17);
      chk("busy16", busy_ok, 1);
      chk("quo16", b16.quotient, e.q);
      chk("rem16", b16.remainder, e.r);
      chk("flags16", {b16.dbz, b16.ovf}, {e.dbz, e.ovf});
   endtask

   // No done and no activity for n cycles.
   task automatic quiet8(input int n);
      bit seen;
      seen = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
         if (b8.done || b8.busy) seen = 1'b1;
      end
      chk("quiet8", seen, 0);
   endtask

   initial begin
      logic [7:0]  ra, rb;
      logic [15:0] wa, wb;
      b8.start = 1'b0;  b8.dividend = '0;  b8.divisor = '0;
      b16.start = 1'b0; b16.dividend = '0; b16.divisor = '0;

      #12;
      chk("rst_out8", {b8.quotient, b8.remainder, b8.done, b8.dbz, b8.ovf}, '0);
      chk("rst_hs8", {b8.ready, b8.busy}, 2'b10);
      chk("rst_out16", {b16.quotient, b16.remainder, b16.done}, '0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic and sign combinations
      op8(8'd100, 8'd7, 1'b0);
      op8(8'h9C, 8'd7, 1'b0);
      op8(8'd100, 8'hF9, 1'b0);
      op8(8'h9C, 8'hF9, 1'b0);
      // Edge cases
      op8(8'd5, 8'd0, 1'b0);
      op8(8'hFB, 8'd0, 1'b0);
      op8(8'h80, 8'hFF, 1'b0);
      op8(8'h80, 8'd1, 1'b0);
      // start held through busy: one result, then silence
      op8(8'd50, 8'd6, 1'b1);
      quiet8(12);
      // back-to-back: second op starts in the done cycle of the first
      op8(8'd77, 8'd10, 1'b0);
      op8(8'd100, 8'd7, 1'b0);

      // Reset at iteration 4 aborts the in-flight operation
      sb8.push_back(model8(8'd120, 8'd11));
      b8.dividend = 8'd120;
      b8.divisor  = 8'd11;
      b8.start    = 1'b1;
      @(posedge clk); #1;
      b8.start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      chk("midrst_out8", {b8.quotient, b8.remainder, b8.done, b8.dbz, b8.ovf}, '0);
      chk("midrst_hs8", {b8.ready, b8.busy}, 2'b10);
      void'(sb8.pop_back());
      @(negedge clk);
      rst_n = 1'b1;
      quiet8(12);
      op8(8'd9, 8'd3, 1'b0);

      // 16-bit unsigned
      op16(16'hFFFF, 16'h0003);
      op16(16'hFFFF, 16'hFFFE);
      op16(16'h1234, 16'h0000);
      op16(16'h8000, 16'h8001);

      for (int i = 0; i < 800; i++) begin
         ra = 8'($urandom);
         rb = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
         if ($urandom_range(0, 19) == 0) begin ra = 8'h80; rb = 8'hFF; end
         op8(ra, rb, 1'b0);
      end
      for (int i = 0; i < 1500; i++) begin
         wa = 16'($urandom);
         wb = ($urandom_range(0, 9) == 0) ? 16'h0 : 16'($urandom >> $urandom_range(0, 15));
         op16(wa, wb);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
